mat_transpose_stream: RTL and testbench
=======================================

MAT_TRANSPOSE_STREAM -- requirements
Module: mat_transpose_stream

Interface
REQ-001 SHALL have parameter M, default 2: matrix row count, >=1.
REQ-002 SHALL have parameter N, default 3: matrix column count, >=1.
REQ-003 SHALL have parameter W, default 32: element width (IEEE-754 single bit pattern, never interpreted).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 in_data  input  W  element of the source matrix, row-major order.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  W  element of the transposed matrix, row-major order of the N x M result.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_last  output  1  high with the final (M*N-th) output element.
REQ-012 busy  output  1  high while in DRAIN.

Function
REQ-013 SHALL implement a two-state FSM: LOAD (accepting input) and DRAIN (emitting output).
REQ-014 In LOAD: in_ready=1, out_valid=0; in_valid&&in_ready stores in_data at buffer[r][c] and advances (r,c) row-major (c wraps N-1->0 with r+1).
REQ-015 The transfer storing element (M-1,N-1) SHALL switch the state to DRAIN on the next edge and reset the index counters to (0,0).
REQ-016 In DRAIN: in_ready=0, out_valid=1, out_data=buffer[r][c], with indices walking column-major (r wraps M-1->0 with c+1), so the output is A^T in row-major order.
REQ-017 out_data, out_valid and out_last SHALL hold stable while out_valid&&!out_ready (no advance, no drop).
REQ-018 out_last SHALL be 1 only when out_valid and (r,c)=(M-1,N-1) in DRAIN.
REQ-019 A handshake with out_last=1 SHALL return the state to LOAD on the next edge with indices (0,0); in_ready rises in that cycle, with no overlap between drain and load (one matrix in flight).
REQ-020 Throughput SHALL be one element per cycle in each phase under continuous valid/ready; latency from the last input handshake to the first out_valid is exactly 1 cycle.
REQ-021 Degenerate shapes M=1 or N=1 SHALL work unchanged (output order equals input order); M=N=1 gives out_last on the single output.
REQ-022 in_valid during DRAIN SHALL be ignored (in_ready=0); out_ready during LOAD SHALL have no effect.
REQ-023 Index counters SHALL be $clog2-sized with a minimum width of 1 and SHALL never exceed M-1 / N-1.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=LOAD, r=c=0, out_valid=0, out_last=0, busy=0, in_ready=1 (after release).
REQ-025 Reset mid-LOAD or mid-DRAIN SHALL discard the partial matrix; the buffer contents need not be cleared.
REQ-026 The first accepted element after reset release SHALL be stored as element (0,0).

Structure
REQ-027 The shared package linalg_pkg SHALL hold the FP_W=32 element-width constant and the state typedef {LOAD, DRAIN}.
REQ-028 The buffer SHALL be an M x N register array (no RAM macro); the read mux is combinational from the index counters.
REQ-029 One sub-module SHALL be used, mat_idx_counter (two-level wrap counter with parameterised inner/outer limits and enable), instantiated once, with its inner/outer roles swapped by state.

Verification
REQ-030 M=2,N=3, inputs 3F800000,40000000,40400000,40800000,40A00000,40C00000 with out_ready=1 -> outputs 3F800000,40800000,40000000,40A00000,40400000,40C00000; out_last on the 6th; in_ready returns the following cycle.
REQ-031 Same data, out_ready toggled 1,0,0,1,... -> identical sequence, out_data held stable during stalls, no duplicates.
REQ-032 Bubbly input (in_valid 1,0,1,1,0,...) -> DRAIN entered exactly 1 cycle after the 6th accepted element; output as REQ-030.
REQ-033 rst_n pulsed low after 3 outputs -> out_valid=0 immediately; a new matrix 1..6 then yields the full REQ-030 sequence.
REQ-034 M=1,N=3, inputs 1,2,3 -> outputs 1,2,3, out_last on 3; M=3,N=1 likewise.
REQ-035 Two back-to-back matrices -> in_ready=0 throughout DRAIN, in_valid there ignored, second matrix transposed correctly.

Source files
------------

// File: rtl/linalg_pkg.sv
// Shared linear-algebra definitions: element width, transpose FSM states
// and the index-width helper used to size row/column counters.
package linalg_pkg;

    localparam int FP_W = 32;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // A counter over n positions never needs fewer than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_transpose_stream_if.sv
// Valid/ready element streams into and out of the matrix transposer.
interface mat_transpose_stream_if
    import linalg_pkg::*;
#(
    parameter int W = FP_W
) ();

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/mat_idx_counter.sv
// Row/column index pair that walks either row-major (column inner) or
// column-major (row inner); both indices wrap to zero after the last cell.
module mat_idx_counter #(
    parameter int R_MAX = 1,
    parameter int C_MAX = 2,
    parameter int RW    = 1,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          col_inner_i,
    output logic [RW-1:0] r_o,
    output logic [CW-1:0] c_o,
    output logic          last_o
);

    localparam logic [RW-1:0] R_LAST = RW'(R_MAX);
    localparam logic [CW-1:0] C_LAST = CW'(C_MAX);

    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (en_i) begin
            if (col_inner_i) begin
                if (c_q == C_LAST) begin
                    c_d = '0;
                    r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
            end else begin
                if (r_q == R_LAST) begin
                    r_d = '0;
                    c_d = (c_q == C_LAST) ? '0 : c_q + CW'(1);
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign last_o = (r_q == R_LAST) && (c_q == C_LAST);

endmodule

// File: rtl/mat_transpose_stream.sv
// Streaming M x N matrix transposer: loads one matrix row-major into a
// register array, then emits it column-major (A^T row-major), one in flight.
module mat_transpose_stream
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3,
    parameter int W = FP_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mat_transpose_stream_if.slave  s,
    output logic                   busy
);

    localparam int RW = idx_w(M);
    localparam int CW = idx_w(N);

    state_t        st_q, st_d;
    logic [RW-1:0] r_idx;
    logic [CW-1:0] c_idx;
    logic          idx_last;
    logic          cnt_en;
    logic          col_inner;
    logic          wr_en;

    logic [W-1:0]  buf_q [M][N];

    // The same counter serves both phases; only the inner index changes.
    mat_idx_counter #(
        .R_MAX (M - 1),
        .C_MAX (N - 1),
        .RW    (RW),
        .CW    (CW)
    ) u_idx (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (cnt_en),
        .col_inner_i (col_inner),
        .r_o         (r_idx),
        .c_o         (c_idx),
        .last_o      (idx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= LOAD;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            LOAD:  if (s.in_valid && idx_last)  st_d = DRAIN;
            DRAIN: if (s.out_ready && idx_last) st_d = LOAD;
        endcase
    end

    always_comb begin
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        s.out_last  = 1'b0;
        busy        = 1'b0;
        cnt_en      = 1'b0;
        col_inner   = 1'b1;
        unique case (st_q)
            LOAD: begin
                s.in_ready = 1'b1;
                cnt_en     = s.in_valid;
                col_inner  = 1'b1;
            end
            DRAIN: begin
                s.out_valid = 1'b1;
                s.out_last  = idx_last;
                busy        = 1'b1;
                cnt_en      = s.out_ready;
                col_inner   = 1'b0;
            end
        endcase
    end

    assign wr_en = (st_q == LOAD) && s.in_valid;

    // Element storage is data only; a reset simply abandons its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[r_idx][c_idx] <= s.in_data;
        end
    end

    assign s.out_data = buf_q[r_idx][c_idx];

endmodule

// File: tb/tb_mat_transpose_stream.sv
// Randomised bench for mat_transpose_stream covering 2x3, 1x3 and 3x1 shapes
// against a cycle-level matrix/queue model, plus literal output tables.
module tb_mat_transpose_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] din  [3];
    logic        vin  [3];
    logic        ordy [3] = '{1'b1, 1'b1, 1'b1};
    logic [31:0] dout [3];
    logic        irdy [3];
    logic        ovld [3];
    logic        olast[3];
    logic        bsy  [3];

    mat_transpose_stream_if #(.W(32)) if0 ();
    mat_transpose_stream_if #(.W(32)) if1 ();
    mat_transpose_stream_if #(.W(32)) if2 ();

    assign if0.in_data = din[0];  assign if0.in_valid = vin[0];  assign if0.out_ready = ordy[0];
    assign if1.in_data = din[1];  assign if1.in_valid = vin[1];  assign if1.out_ready = ordy[1];
    assign if2.in_data = din[2];  assign if2.in_valid = vin[2];  assign if2.out_ready = ordy[2];
    assign dout[0] = if0.out_data; assign irdy[0] = if0.in_ready; assign ovld[0] = if0.out_valid; assign olast[0] = if0.out_last;
    assign dout[1] = if1.out_data; assign irdy[1] = if1.in_ready; assign ovld[1] = if1.out_valid; assign olast[1] = if1.out_last;
    assign dout[2] = if2.out_data; assign irdy[2] = if2.in_ready; assign ovld[2] = if2.out_valid; assign olast[2] = if2.out_last;

    mat_transpose_stream #(.M(2), .N(3), .W(32)) u0 (.clk(clk), .rst_n(rst_n), .s(if0), .busy(bsy[0]));
    mat_transpose_stream #(.M(1), .N(3), .W(32)) u1 (.clk(clk), .rst_n(rst_n), .s(if1), .busy(bsy[1]));
    mat_transpose_stream #(.M(3), .N(1), .W(32)) u2 (.clk(clk), .rst_n(rst_n), .s(if2), .busy(bsy[2]));

    // Behavioural model: per instance, the loaded matrix and the output position.
    int          mm[3] = '{2, 1, 3};
    int          nn[3] = '{3, 3, 1};
    logic [31:0] mat [3][9];
    int          cnt [3];
    int          oi  [3];
    int          gcnt[3];
    bit          drain[3];
    logic [31:0] got [3][64];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;
    int omode    = 0;
    int ph       = 0;

    logic [31:0] sdat[9];
    logic [31:0] sexp[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tot_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    endtask

    // Output number o of A^T (row-major N x M) is A[o % M][o / M].
    function automatic logic [31:0] exp_elem(input int k);
        int i, j;
        i = oi[k] % mm[k];
        j = oi[k] / mm[k];
        return mat[k][i * nn[k] + j];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                drain[k] <= 1'b0;
                cnt[k]   <= 0;
                oi[k]    <= 0;
                gcnt[k]  <= 0;
            end else if (!drain[k]) begin
                if (vin[k] === 1'b1) begin
                    mat[k][cnt[k]] <= din[k];
                    cnt[k] <= cnt[k] + 1;
                    if (cnt[k] + 1 == mm[k] * nn[k]) begin
                        drain[k] <= 1'b1;
                        oi[k]    <= 0;
                    end
                end
            end else if (ordy[k] === 1'b1) begin
                got[k][gcnt[k] % 64] <= dout[k];
                gcnt[k] <= gcnt[k] + 1;
                oi[k]   <= oi[k] + 1;
                if (oi[k] + 1 == mm[k] * nn[k]) begin
                    drain[k] <= 1'b0;
                    cnt[k]   <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    chk("out_valid_in_reset", 32'(ovld[k]), 32'd0);
                end else begin
                    chk("in_ready", 32'(irdy[k]), 32'(!drain[k]));
                    chk("out_valid", 32'(ovld[k]), 32'(drain[k]));
                    chk("busy", 32'(bsy[k]), 32'(drain[k]));
                    if (drain[k]) begin
                        chk("out_data", dout[k], exp_elem(k));
                        chk("out_last", 32'(olast[k]), 32'(oi[k] == mm[k] * nn[k] - 1));
                    end else begin
                        chk("out_last_idle", 32'(olast[k]), 32'd0);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        ph++;
        for (int k = 0; k < 3; k++) begin
            case (omode)
                0:       ordy[k] = 1'b1;
                1:       ordy[k] = (ph % 3 == 0);
                default: ordy[k] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input int k, input int n, input bit bub);
        bit acc, a;
        int t;
        for (int i = 0; i < n; i++) begin
            if (bub && ($urandom_range(0, 2) == 0)) begin
                vin[k] = 1'b0;
                @(posedge clk); #1;
            end
            vin[k] = 1'b1;
            din[k] = sdat[i];
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                a = irdy[k];
                @(posedge clk); #1;
                acc = a;
                t++;
            end
            if (!acc) chk("send_timeout", 32'd0, 32'd1);
        end
        vin[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int t;
        t = 0;
        while (drain[k] && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (drain[k]) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_case(input int k, input int n, input bit bub, input string nm);
        int base;
        base = gcnt[k];
        send(k, n, bub);
        wait_done(k);
        chk({nm, "_count"}, 32'(gcnt[k] - base), 32'(n));
        for (int i = 0; i < n; i++) chk(nm, got[k][(base + i) % 64], sexp[i]);
    endtask

    task automatic load_ref();
        sdat = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h0, 32'h0, 32'h0};
        sexp = '{32'h3F800000, 32'h40800000, 32'h40000000, 32'h40A00000,
                 32'h40400000, 32'h40C00000, 32'h0, 32'h0, 32'h0};
    endtask

    initial begin
        int base, t;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b0;
            din[k] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst_n  = 1'b1;
        #1;
        chk("reset_in_ready", 32'(irdy[0]), 32'd1);
        chk("reset_out_valid", 32'(ovld[0]), 32'd0);
        chk("reset_out_last", 32'(olast[0]), 32'd0);
        chk("reset_busy", 32'(bsy[0]), 32'd0);
        @(posedge clk); #1;

        load_ref();
        omode = 0;
        run_case(0, 6, 1'b0, "ref_2x3");
        omode = 1;
        run_case(0, 6, 1'b0, "stall_2x3");
        omode = 0;
        run_case(0, 6, 1'b1, "bubbly_2x3");

        // Abort a drain part-way through and check the next matrix is whole.
        base = gcnt[0];
        send(0, 6, 1'b0);
        t = 0;
        while ((gcnt[0] - base) < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if ((gcnt[0] - base) < 3) chk("mid_drain_timeout", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(ovld[0]), 32'd0);
        chk("async_rst_busy", 32'(bsy[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_ref();
        run_case(0, 6, 1'b0, "after_reset_2x3");

        sdat = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        sexp = sdat;
        run_case(1, 3, 1'b0, "shape_1x3");
        run_case(2, 3, 1'b0, "shape_3x1");

        // Second matrix presented while the first drains.
        for (int i = 0; i < 6; i++) sdat[i] = $urandom;
        send(0, 6, 1'b0);
        for (int i = 0; i < 6; i++) sdat[i] = $urandom;
        send(0, 6, 1'b0);
        wait_done(0);

        omode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 9; i++) sdat[i] = $urandom;
                send(k, mm[k] * nn[k], 1'b1);
                wait_done(k);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
